axi_read_arbiter_rr: RTL and testbench
======================================

Name: axi_read_arbiter_rr

Overview:
- Parametrised round-robin arbiter for the shared AXI read channel.
- Replaces the fixed three-master read side of the memory arbiter.
- Masters such as i_cache, d_cache and the stream buffer each present one AR/R port pair; the arbiter serialises them onto one AXI read port.
- Exactly one burst is outstanding at a time; grant order is fair.

Parameters:
- MASTERS, 3, number of read masters (2..8).
- ADDR_WIDTH, 26, byte address width; matches `ADDR_WIDTH.
- DATA_WIDTH, 32, beat width; matches `DATA_WIDTH.
- ID_WIDTH, 4, AXI ID width; must satisfy 2**ID_WIDTH >= MASTERS.
- LEN_WIDTH, 4, AXI burst length field width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m_arvalid  in  MASTERS  per-master address request
- m_araddr  in  MASTERS*ADDR_WIDTH  per-master address, packed, master i at slice i
- m_arlen  in  MASTERS*LEN_WIDTH  per-master burst length minus one
- m_arready  out  MASTERS  per-master address accept
- m_rvalid  out  MASTERS  per-master beat valid
- m_rlast  out  MASTERS  per-master last beat
- m_rdata  out  DATA_WIDTH  beat data, shared by all masters
- m_rready  in  MASTERS  per-master beat accept
- ARVALID  out  1  AXI address valid
- ARREADY  in  1  AXI address ready
- ARID  out  ID_WIDTH  AXI ID
- ARLEN  out  LEN_WIDTH  AXI burst length
- ARADDR  out  ADDR_WIDTH  AXI address
- RVALID  in  1  AXI beat valid
- RREADY  out  1  AXI beat ready
- RLAST  in  1  AXI last beat
- RID  in  ID_WIDTH  AXI beat ID
- RDATA  in  DATA_WIDTH  AXI beat data

Behaviour:
- Reset: state IDLE, rr_ptr=0, grant=0, ARVALID=0, ARID/ARLEN/ARADDR=0, RREADY=0, m_arready=0, m_rvalid=0, m_rlast=0. Reset takes effect immediately, including mid-burst. Any in-flight beats after reset are not forwarded.
- State IDLE:
  - If any m_arvalid is set, pick the first requesting index at or after rr_ptr, wrapping modulo MASTERS.
  - Latch grant, m_araddr, m_arlen; pulse m_arready[grant] for 1 cycle.
  - Go to ADDR.
  - No requests: stay in IDLE.
- State ADDR:
  - ARVALID=1; ARID=grant zero-extended; ARADDR/ARLEN from the latches, held stable while ARVALID=1.
  - On ARVALID&&ARREADY: go to DATA.
- State DATA:
  - RREADY = m_rready[grant] && (RID==grant).
  - m_rvalid[grant] = RVALID && (RID==grant); m_rlast[grant]=RLAST; m_rdata=RDATA.
  - All other masters see m_rvalid=0. These paths are combinational pass-through.
  - On RVALID&&RREADY&&RLAST: go to IDLE and set rr_ptr=(grant+1) mod MASTERS; the wrap from MASTERS-1 goes to 0.
- Latency: request to ARVALID is 2 cycles (IDLE accept, then ADDR). There is 1 idle bubble between the RLAST handshake and the next grant.
- Master i is granted again only after every other requesting master has been served once.
- Beats with RID != grant are never accepted: RREADY stays 0 and the arbiter stalls.
- m_arvalid dropping after the grant is ignored; the latched request completes.
- Simultaneous requests from all masters with rr_ptr=k: master k wins.
- A single-beat burst (ARLEN=0) exits DATA on its first beat.

Optional Feature:
- Macro: ARB_PERF_CNT_EN
- Defined:
  - Adds 32-bit per-master grant counters and wait-cycle counters. A wait cycle is m_arvalid[i]=1 while master i is not being accepted.
  - Counters saturate at 2**32-1 and clear on reset.
  - Under `ifdef SIMULATION, they are printed via $display at the first cycle done is observed high on a perf_dump input port. That port exists only with the macro.
- Undefined: no counters and no extra port; behaviour is otherwise identical.

Decomposition:
- Shared package (mips_core_pkg or the existing header):
  - typedef enum arb_state_t {ARB_IDLE, ARB_ADDR, ARB_DATA}.
  - Constants ARB_MAX_MASTERS=8.
  - Function rr_pick(req, ptr) returning the granted index.
- One natural sub-module: rr_priority_picker. It is combinational and parametrised by MASTERS, with inputs req[MASTERS] and ptr and outputs grant_idx and any_req. It is reusable for a future write-side arbiter.

Test Plan:
- MASTERS=3, only m1 requests addr 0x000040, len 3 -> ARVALID 2 cycles later, ARID=1, ARADDR=0x000040, ARLEN=3. 4 beats reach m1 only; m_rlast[1] on beat 4; rr_ptr=2.
- All 3 request continuously with rr_ptr=0 -> grant order 0,1,2,0. Each is granted exactly once per 3 bursts.
- RID=2 beat arrives while grant=0 -> RREADY=0, no m_rvalid asserted, state stays DATA until an RID=0 beat.
- m_rready[0]=0 for 3 cycles mid-burst -> RREADY=0, beat held; no beat is lost or duplicated.
- rst_n low during beat 2 of a 4-beat burst -> same cycle: ARVALID=0, RREADY=0, all m_rvalid=0. After release: state IDLE, rr_ptr=0.
- MASTERS=8, ID_WIDTH=4, m7 requests then m0 -> m7 is served, rr_ptr wraps to 0, then m0 gets ARID=0.

Source files
------------

// File: rtl/axi_read_arbiter_rr_pkg.sv
// -----------------------------------------------------------------------------
// axi_read_arbiter_rr_pkg
// Shared definitions for the round-robin AXI read arbiter:
//   arb_state_t     - arbiter FSM states (IDLE -> ADDR -> DATA -> IDLE)
//   ARB_MAX_MASTERS - largest supported master count
//   rr_pick()       - round-robin pick: first requester at or after ptr,
//                     wrapping modulo the active master count
// No ports (package).
// -----------------------------------------------------------------------------
package axi_read_arbiter_rr_pkg;

  localparam int ARB_MAX_MASTERS = 8;
  localparam int ARB_IDX_W       = 3;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  // req/ptr are sized for the largest configuration; callers zero-extend.
  // When nothing is requested the result is ptr (callers gate with any_req).
  function automatic logic [ARB_IDX_W-1:0] rr_pick(
    input logic [ARB_MAX_MASTERS-1:0] req,
    input logic [ARB_IDX_W-1:0]       ptr,
    input int                         masters
  );
    logic [ARB_IDX_W-1:0] result;
    logic                 found;
    int                   idx;
    result = ptr;
    found  = 1'b0;
    for (int k = 0; k < ARB_MAX_MASTERS; k++) begin
      idx = (int'(ptr) + k) % masters;
      if ((k < masters) && !found && req[idx]) begin
        result = ARB_IDX_W'(idx);
        found  = 1'b1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin picker, reusable by read and write arbiters.
// Ports:
//   req       in  MASTERS  request vector
//   ptr       in  PTR_W    index with highest priority this round
//   grant_idx out PTR_W    first requesting index at or after ptr (wrapping)
//   any_req   out 1        at least one request present
// -----------------------------------------------------------------------------
module rr_priority_picker
  import axi_read_arbiter_rr_pkg::*;
#(
  parameter int MASTERS = 3,
  parameter int PTR_W   = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic [MASTERS-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any_req
);

  always_comb begin
    grant_idx = PTR_W'(rr_pick(ARB_MAX_MASTERS'(req), ARB_IDX_W'(ptr), MASTERS));
    any_req   = |req;
  end

endmodule

// File: rtl/axi_read_arbiter_rr.sv
// -----------------------------------------------------------------------------
// axi_read_arbiter_rr
// Round-robin arbiter that serialises MASTERS read masters onto a single AXI
// read port. One burst is outstanding at a time.
//
// Optional feature macro: ARB_PERF_CNT_EN (per-master grant / wait counters,
// adds the perf_dump input; dump printing additionally needs SIMULATION).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   perf_dump           (ARB_PERF_CNT_EN only) print counters on first high
//   m_arvalid/m_araddr/m_arlen/m_arready   per-master address channel (packed)
//   m_rvalid/m_rlast/m_rready              per-master read data handshake
//   m_rdata                                shared beat data
//   ARVALID/ARREADY/ARID/ARLEN/ARADDR      AXI address channel
//   RVALID/RREADY/RLAST/RID/RDATA          AXI read data channel
//   dbg_state           FSM state (arb_state_t encoding)
//   dbg_rr_ptr          current round-robin pointer
//
// Handshake semantics: every channel transfers on the cycle where its valid
// and ready are both high at the rising clock edge. m_arready is a one-cycle
// accept pulse in IDLE; the master may drop m_arvalid afterwards, the latched
// request still completes.
// -----------------------------------------------------------------------------
module axi_read_arbiter_rr
  import axi_read_arbiter_rr_pkg::*;
#(
  parameter  int MASTERS    = 3,
  parameter  int ADDR_WIDTH = 26,
  parameter  int DATA_WIDTH = 32,
  parameter  int ID_WIDTH   = 4,
  parameter  int LEN_WIDTH  = 4,
  localparam int PTR_W      = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef ARB_PERF_CNT_EN
  input  logic                          perf_dump,
`endif
  input  logic [MASTERS-1:0]            m_arvalid,
  input  logic [MASTERS*ADDR_WIDTH-1:0] m_araddr,
  input  logic [MASTERS*LEN_WIDTH-1:0]  m_arlen,
  output logic [MASTERS-1:0]            m_arready,
  output logic [MASTERS-1:0]            m_rvalid,
  output logic [MASTERS-1:0]            m_rlast,
  output logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic [MASTERS-1:0]            m_rready,
  output logic                          ARVALID,
  input  logic                          ARREADY,
  output logic [ID_WIDTH-1:0]           ARID,
  output logic [LEN_WIDTH-1:0]          ARLEN,
  output logic [ADDR_WIDTH-1:0]         ARADDR,
  input  logic                          RVALID,
  output logic                          RREADY,
  input  logic                          RLAST,
  input  logic [ID_WIDTH-1:0]           RID,
  input  logic [DATA_WIDTH-1:0]         RDATA,
  output logic [1:0]                    dbg_state,
  output logic [PTR_W-1:0]              dbg_rr_ptr
);

  localparam logic [1:0] S_IDLE = ARB_IDLE;
  localparam logic [1:0] S_ADDR = ARB_ADDR;
  localparam logic [1:0] S_DATA = ARB_DATA;

  logic [1:0]            state;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      grant;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;

  logic [PTR_W-1:0]      pick_idx;
  logic                  any_req;
  logic                  id_match;
  logic                  burst_done;
  logic [PTR_W-1:0]      next_ptr;

  rr_priority_picker #(
    .MASTERS (MASTERS),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req       (m_arvalid),
    .ptr       (rr_ptr),
    .grant_idx (pick_idx),
    .any_req   (any_req)
  );

  // Beats tagged for another ID are never accepted; the arbiter just stalls.
  assign id_match   = (RID == ID_WIDTH'(grant));
  assign burst_done = (state == S_DATA) && RVALID && RREADY && RLAST;
  assign next_ptr   = (grant == PTR_W'(MASTERS - 1)) ? '0 : grant + PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      rr_ptr <= '0;
      grant  <= '0;
      addr_q <= '0;
      len_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant  <= pick_idx;
            addr_q <= m_araddr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            len_q  <= m_arlen[pick_idx*LEN_WIDTH +: LEN_WIDTH];
            state  <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (ARREADY) state <= S_DATA;
        end
        S_DATA: begin
          if (burst_done) begin
            rr_ptr <= next_ptr;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    m_rlast   = '0;
    RREADY    = 1'b0;
    // rst_n gates the accept pulse so a request seen during reset is not
    // acknowledged while the FSM is held in IDLE.
    if ((state == S_IDLE) && any_req && rst_n) m_arready[pick_idx] = 1'b1;
    if (state == S_DATA) begin
      m_rvalid[grant] = RVALID && id_match;
      m_rlast[grant]  = RLAST;
      RREADY          = m_rready[grant] && id_match;
    end
  end

  assign ARVALID    = (state == S_ADDR);
  assign ARID       = ARVALID ? ID_WIDTH'(grant) : '0;
  assign ARADDR     = ARVALID ? addr_q : '0;
  assign ARLEN      = ARVALID ? len_q : '0;
  assign m_rdata    = RDATA;
  assign dbg_state  = state;
  assign dbg_rr_ptr = rr_ptr;

`ifdef ARB_PERF_CNT_EN
  // Saturating per-master counters: accepted requests, and cycles spent
  // requesting without being accepted.
  logic [31:0] grant_cnt [MASTERS];
  logic [31:0] wait_cnt  [MASTERS];
  logic        dumped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MASTERS; i++) begin
        grant_cnt[i] <= '0;
        wait_cnt[i]  <= '0;
      end
      dumped <= 1'b0;
    end else begin
      for (int i = 0; i < MASTERS; i++) begin
        if (m_arready[i] && (grant_cnt[i] != 32'hFFFF_FFFF))
          grant_cnt[i] <= grant_cnt[i] + 32'd1;
        if (m_arvalid[i] && !m_arready[i] && (wait_cnt[i] != 32'hFFFF_FFFF))
          wait_cnt[i] <= wait_cnt[i] + 32'd1;
      end
      if (perf_dump && !dumped) begin
        dumped <= 1'b1;
`ifdef SIMULATION
        for (int i = 0; i < MASTERS; i++)
          $display("arb perf master %0d: grants %0d wait_cycles %0d",
                   i, grant_cnt[i], wait_cnt[i]);
`endif
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_read_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_axi_read_arbiter_rr
// Bench for axi_read_arbiter_rr: a 3-master instance driven with directed and
// random bursts against a round-robin reference model, plus an 8-master
// instance for the pointer wrap case.
// -----------------------------------------------------------------------------
module tb_axi_read_arbiter_rr;

  localparam int M  = 3;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int LW = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 3-master DUT ----------------
  logic [M-1:0]    m_arvalid;
  logic [M*AW-1:0] m_araddr;
  logic [M*LW-1:0] m_arlen;
  logic [M-1:0]    m_arready;
  logic [M-1:0]    m_rvalid;
  logic [M-1:0]    m_rlast;
  logic [DW-1:0]   m_rdata;
  logic [M-1:0]    m_rready;
  logic            ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic [IW-1:0]   ARID, RID;
  logic [LW-1:0]   ARLEN;
  logic [AW-1:0]   ARADDR;
  logic [DW-1:0]   RDATA;
  logic [1:0]      dbg_state;
  logic [1:0]      dbg_rr_ptr;

  axi_read_arbiter_rr #(.MASTERS(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .ID_WIDTH(IW), .LEN_WIDTH(LW)) u_dut (
    .clk(clk), .rst_n(rst_n),
`ifdef ARB_PERF_CNT_EN
    .perf_dump(1'b0),
`endif
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rlast(m_rlast),
    .m_rdata(m_rdata), .m_rready(m_rready),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN),
    .ARADDR(ARADDR), .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST),
    .RID(RID), .RDATA(RDATA), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  // ---------------- 8-master DUT ----------------
  logic [7:0]      d8_arvalid;
  logic [8*AW-1:0] d8_araddr;
  logic [8*LW-1:0] d8_arlen;
  logic [7:0]      d8_arready, d8_rvalid, d8_rlast, d8_rready;
  logic [DW-1:0]   d8_rdata;
  logic            d8_ARVALID, d8_ARREADY, d8_RVALID, d8_RREADY, d8_RLAST;
  logic [IW-1:0]   d8_ARID, d8_RID;
  logic [LW-1:0]   d8_ARLEN;
  logic [AW-1:0]   d8_ARADDR;
  logic [DW-1:0]   d8_RDATA;
  logic [1:0]      d8_dbg_state;
  logic [2:0]      d8_dbg_rr_ptr;

  axi_read_arbiter_rr #(.MASTERS(8), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .ID_WIDTH(IW), .LEN_WIDTH(LW)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
`ifdef ARB_PERF_CNT_EN
    .perf_dump(1'b0),
`endif
    .m_arvalid(d8_arvalid), .m_araddr(d8_araddr), .m_arlen(d8_arlen),
    .m_arready(d8_arready), .m_rvalid(d8_rvalid), .m_rlast(d8_rlast),
    .m_rdata(d8_rdata), .m_rready(d8_rready),
    .ARVALID(d8_ARVALID), .ARREADY(d8_ARREADY), .ARID(d8_ARID),
    .ARLEN(d8_ARLEN), .ARADDR(d8_ARADDR), .RVALID(d8_RVALID),
    .RREADY(d8_RREADY), .RLAST(d8_RLAST), .RID(d8_RID), .RDATA(d8_RDATA),
    .dbg_state(d8_dbg_state), .dbg_rr_ptr(d8_dbg_rr_ptr)
  );

  // ---------------- scoreboard / model state ----------------
  int          checks = 0;
  int          errors = 0;
  int          model_ptr = 0;
  logic [DW-1:0] exp_q[$];
  int          grant_log[$];

  // Reference rule: first requester at or after ptr, wrapping modulo M.
  function automatic int model_pick(input logic [M-1:0] req, input int ptr);
    for (int k = 0; k < M; k++) begin
      if (req[(ptr + k) % M]) return (ptr + k) % M;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
  endtask

  // Serves one burst. Called during an IDLE cycle (before the rising edge)
  // with the m_ar* inputs already driven. Returns in the following IDLE cycle.
  task automatic serve_one(input bit drop_req, input int foreign_at,
                           input int stall_at, input int reset_at);
    int            w, len, n, tries;
    logic [AW-1:0] addr;
    logic [DW-1:0] d;
    logic [M-1:0]  oh;
    bit            done;
    w = model_pick(m_arvalid, model_ptr);
    if (w < 0) begin
      checks++; errors++;
      $display("FAIL serve_setup: no request driven, required at least one");
      return;
    end
    oh   = M'(1 << w);
    len  = int'(m_arlen[w*LW +: LW]);
    addr = m_araddr[w*AW +: AW];
    #1;
    checks++;
    if (m_arready !== oh) begin
      errors++; $display("FAIL arready: got %b required %b", m_arready, oh);
    end
    // Address phase appears on the cycle after the accept.
    @(negedge clk);
    if (drop_req) m_arvalid = '0;
    #1;
    checks++;
    if (ARVALID !== 1'b1 || ARID !== IW'(w) || ARADDR !== addr || ARLEN !== LW'(len)) begin
      errors++;
      $display("FAIL ar_issue: got v=%b id=%0d addr=%h len=%0d required v=1 id=%0d addr=%h len=%0d",
               ARVALID, ARID, ARADDR, ARLEN, w, addr, len);
    end
    n = $urandom_range(0, 2);
    repeat (n) begin
      @(negedge clk);
      #1;
      checks++;
      if (ARVALID !== 1'b1 || ARADDR !== addr) begin
        errors++; $display("FAIL ar_hold: got v=%b addr=%h required v=1 addr=%h", ARVALID, ARADDR, addr);
      end
    end
    ARREADY = 1'b1;
    @(negedge clk);
    ARREADY = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if (b == foreign_at) begin
        RVALID = 1'b1; RID = IW'((w + 2) % M); RLAST = 1'b1; RDATA = $urandom;
        m_rready = '1;
        repeat (3) begin
          #1;
          checks++;
          if (RREADY !== 1'b0 || m_rvalid !== '0) begin
            errors++; $display("FAIL foreign_id: got rready=%b m_rvalid=%b required 0 and 000", RREADY, m_rvalid);
          end
          @(negedge clk);
        end
        #1;
        checks++;
        if (dbg_state !== 2'd2) begin
          errors++; $display("FAIL foreign_state: got %0d required 2", dbg_state);
        end
      end
      d = $urandom;
      exp_q.push_back(d);
      RVALID = 1'b1; RID = IW'(w); RDATA = d; RLAST = (b == len);
      if (b == reset_at) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (ARVALID !== 1'b0 || RREADY !== 1'b0 || m_rvalid !== '0 || m_rlast !== '0) begin
          errors++; $display("FAIL reset_mid: got arvalid=%b rready=%b m_rvalid=%b m_rlast=%b required all 0",
                             ARVALID, RREADY, m_rvalid, m_rlast);
        end
        @(negedge clk);
        rst_n = 1'b1; RVALID = 1'b0; RLAST = 1'b0; m_arvalid = '0; m_rready = '0;
        #1;
        checks++;
        if (dbg_state !== 2'd0 || dbg_rr_ptr !== 2'd0) begin
          errors++; $display("FAIL reset_release: got state=%0d ptr=%0d required 0 0", dbg_state, dbg_rr_ptr);
        end
        model_ptr = 0;
        exp_q.delete();
        return;
      end
      tries = 0;
      done  = 1'b0;
      while (!done) begin
        m_rready = '0;
        if (b == stall_at) m_rready[w] = (tries >= 3);
        else m_rready[w] = (tries >= 3) || ($urandom_range(0, 2) != 0);
        #1;
        checks++;
        if (m_rvalid !== oh || RREADY !== m_rready[w]) begin
          errors++; $display("FAIL beat_valid: got m_rvalid=%b rready=%b required %b %b", m_rvalid, RREADY, oh, m_rready[w]);
        end
        if (RREADY === 1'b1) begin
          d = exp_q.pop_front();
          checks++;
          if (m_rdata !== d || m_rlast[w] !== 1'(b == len)) begin
            errors++; $display("FAIL beat_data: got data=%h last=%b required %h %b", m_rdata, m_rlast[w], d, (b == len));
          end
          done = 1'b1;
        end
        @(negedge clk);
        tries++;
      end
    end
    RVALID = 1'b0; RLAST = 1'b0; m_rready = '0;
    grant_log.push_back(w);
    model_ptr = (w + 1) % M;
    #1;
    checks++;
    if (dbg_state !== 2'd0 || dbg_rr_ptr !== 2'(model_ptr)) begin
      errors++; $display("FAIL burst_end: got state=%0d ptr=%0d required 0 %0d", dbg_state, dbg_rr_ptr, model_ptr);
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    m_arvalid = '1;
    @(negedge clk);
    #1;
    checks++;
    if (ARVALID !== 1'b0 || RREADY !== 1'b0 || m_arready !== '0 || m_rvalid !== '0 ||
        m_rlast !== '0 || ARID !== '0 || ARLEN !== '0 || ARADDR !== '0 ||
        dbg_state !== 2'd0 || dbg_rr_ptr !== 2'd0) begin
      errors++; $display("FAIL reset_state: got arvalid=%b rready=%b arready=%b rvalid=%b state=%0d ptr=%0d required all 0",
                         ARVALID, RREADY, m_arready, m_rvalid, dbg_state, dbg_rr_ptr);
    end
    @(negedge clk);
    m_arvalid = '0;
    rst_n = 1'b1;
    model_ptr = 0;
  endtask

  task automatic test_single_m1();
    m_arvalid = 3'b010;
    m_araddr[1*AW +: AW] = 26'h000040;
    m_arlen[1*LW +: LW]  = 4'd3;
    serve_one(1'b1, -1, -1, -1);
    checks++;
    if (dbg_rr_ptr !== 2'd2) begin
      errors++; $display("FAIL single_ptr: got %0d required 2", dbg_rr_ptr);
    end
  endtask

  task automatic test_all_continuous();
    int order[4];
    order = '{0, 1, 2, 0};
    grant_log.delete();
    m_arvalid = '1;
    for (int i = 0; i < M; i++) begin
      m_araddr[i*AW +: AW] = AW'(i * 256);
      m_arlen[i*LW +: LW]  = LW'($urandom_range(0, 3));
    end
    repeat (4) serve_one(1'b0, -1, -1, -1);
    m_arvalid = '0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (grant_log[i] !== order[i]) begin
        errors++; $display("FAIL rr_order[%0d]: got %0d required %0d", i, grant_log[i], order[i]);
      end
    end
  endtask

  task automatic test_rid_mismatch();
    m_arvalid = 3'b001;
    m_araddr[0 +: AW] = 26'h0001F0;
    m_arlen[0 +: LW]  = 4'd1;
    serve_one(1'b1, 0, -1, -1);
  endtask

  task automatic test_rready_stall();
    m_arvalid = 3'b001;
    m_araddr[0 +: AW] = 26'h000300;
    m_arlen[0 +: LW]  = 4'd3;
    serve_one(1'b1, -1, 1, -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      m_arvalid = M'($urandom_range(1, 7));
      for (int i = 0; i < M; i++) begin
        m_araddr[i*AW +: AW] = AW'($urandom);
        m_arlen[i*LW +: LW]  = LW'($urandom_range(0, 5));
      end
      serve_one(1'($urandom_range(0, 1)), -1, -1, -1);
    end
    m_arvalid = '0;
  endtask

  task automatic test_reset_mid_burst();
    m_arvalid = 3'b001;
    m_araddr[0 +: AW] = 26'h000500;
    m_arlen[0 +: LW]  = 4'd3;
    serve_one(1'b1, -1, -1, 1);
  endtask

  task automatic test_wrap8();
    @(negedge clk);
    d8_arvalid = 8'h80;
    d8_araddr[7*AW +: AW] = 26'h000123;
    d8_arlen[7*LW +: LW]  = 4'd0;
    #1;
    checks++;
    if (d8_arready !== 8'h80) begin
      errors++; $display("FAIL w8_accept7: got %b required 10000000", d8_arready);
    end
    @(negedge clk);
    d8_arvalid = '0;
    #1;
    checks++;
    if (d8_ARVALID !== 1'b1 || d8_ARID !== 4'd7 || d8_ARADDR !== 26'h000123) begin
      errors++; $display("FAIL w8_ar7: got v=%b id=%0d addr=%h required 1 7 000123", d8_ARVALID, d8_ARID, d8_ARADDR);
    end
    d8_ARREADY = 1'b1;
    @(negedge clk);
    d8_ARREADY = 1'b0;
    d8_RVALID = 1'b1; d8_RID = 4'd7; d8_RLAST = 1'b1; d8_RDATA = 32'hA5A5_0007;
    d8_rready = 8'h80;
    #1;
    checks++;
    if (d8_rvalid !== 8'h80 || d8_RREADY !== 1'b1 || d8_rlast[7] !== 1'b1 || d8_rdata !== 32'hA5A5_0007) begin
      errors++; $display("FAIL w8_beat7: got rvalid=%b rready=%b rlast=%b data=%h required 10000000 1 1 a5a50007",
                         d8_rvalid, d8_RREADY, d8_rlast[7], d8_rdata);
    end
    @(negedge clk);
    d8_RVALID = 1'b0; d8_RLAST = 1'b0; d8_rready = '0;
    d8_arvalid = 8'h81;
    d8_araddr[0 +: AW] = 26'h000200;
    d8_arlen[0 +: LW]  = 4'd0;
    #1;
    checks++;
    if (d8_dbg_rr_ptr !== 3'd0 || d8_arready !== 8'h01) begin
      errors++; $display("FAIL w8_wrap: got ptr=%0d arready=%b required 0 00000001", d8_dbg_rr_ptr, d8_arready);
    end
    @(negedge clk);
    d8_arvalid = '0;
    #1;
    checks++;
    if (d8_ARVALID !== 1'b1 || d8_ARID !== 4'd0 || d8_ARADDR !== 26'h000200) begin
      errors++; $display("FAIL w8_ar0: got v=%b id=%0d addr=%h required 1 0 000200", d8_ARVALID, d8_ARID, d8_ARADDR);
    end
    d8_ARREADY = 1'b1;
    @(negedge clk);
    d8_ARREADY = 1'b0;
    d8_RVALID = 1'b1; d8_RID = 4'd0; d8_RLAST = 1'b1; d8_RDATA = 32'h0;
    d8_rready = 8'h01;
    @(negedge clk);
    d8_RVALID = 1'b0; d8_RLAST = 1'b0; d8_rready = '0;
    #1;
    checks++;
    if (d8_dbg_state !== 2'd0 || d8_dbg_rr_ptr !== 3'd1) begin
      errors++; $display("FAIL w8_end: got state=%0d ptr=%0d required 0 1", d8_dbg_state, d8_dbg_rr_ptr);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_rready = '0;
    ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RID = '0; RDATA = '0;
    d8_arvalid = '0; d8_araddr = '0; d8_arlen = '0; d8_rready = '0;
    d8_ARREADY = 1'b0; d8_RVALID = 1'b0; d8_RLAST = 1'b0; d8_RID = '0; d8_RDATA = '0;

    test_reset();
    test_single_m1();
    apply_reset();
    test_all_continuous();
    test_rid_mismatch();
    test_rready_stall();
    test_random();
    test_reset_mid_burst();
    test_wrap8();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
